ita_requant_pipe: RTL
=====================

Name: ita_requant_pipe

Overview:
Pipelined requantizer between the ITA accumulator output and the output FIFO. It takes N signed WO-bit accumulator lanes per beat and produces N signed WI-bit lanes. Each beat is scaled by eps_mult, rounded and right-shifted, offset by add, then clipped. The requant constant set is selected per beat from the step tag travelling with the data. Valid/ready on both sides, three register stages, full throughput.

Parameters:
N, 16, lanes per beat
WO, 26, accumulator lane width (signed)
WI, 8, output lane width (signed)
EMS, 8, width of eps_mult and right_shift
N_CONSTS, 8, number of requant constant sets (N_ATTENTION_STEPS + N_FEEDFORWARD_STEPS)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i & ready_o
data_i  in  N*WO  oup_t, lane k at [k*WO +: WO]
step_i  in  step_e  step tag of the beat
eps_mult_i  in  N_CONSTS*EMS  requant_const_array_t
right_shift_i  in  N_CONSTS*EMS  requant_const_array_t
add_i  in  N_CONSTS*WI  requant_array_t (signed)
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
data_o  out  N*WI  requant_oup_t
count_clear_i  in  1  synchronous clear of out_count_o
out_count_o  out  counter_t  number of output handshakes since clear
illegal_step_o  out  1  one-cycle pulse when a beat tagged Idle is accepted
busy_o  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset values: valid_o=0, data_o=0, out_count_o=0, illegal_step_o=0, busy_o=0. All stage valid bits are cleared.
- A reset asserted mid-stream discards every in-flight beat at the next edge.
- Constant index by step: Q=0, K=1, V=2, QK=3, AV=4, OW=5, F1=6, F2=7, MatMul=6.
- Idle beats are accepted but dropped (no output), and illegal_step_o pulses.
- The constant index is captured with the beat in S1, so constants are per beat.
- Constant ports are sampled only at S1 capture. Changing them mid-stream affects only later beats.
- S1 (multiply): p = data * $unsigned(eps_mult). Signed result, WO+EMS+1 = 35 bits.
- S2 (round/shift): sh = right_shift.
  - If sh>0: q = (p + 2^(sh-1)) >>> sh, arithmetic.
  - If sh=0: q = p.
  - sh >= 35 saturates to 34 (result is 0 or -1).
- S3 (offset/clip): r = q + sign-extended add, with no overflow.
  - Clip r to [-2^(WI-1), 2^(WI-1)-1], then register it to data_o.
- Handshake and flow:
  - A stage advances if the downstream stage is empty or advancing. Stage S3 advances on ready_i.
  - Bubbles collapse.
  - ready_o = ~S1.valid | S1 advancing.
  - Latency from input handshake to valid_o is 3 cycles. With ready_i held high, throughput is 1 beat/cycle.
- data_o and valid_o stay stable while valid_o & ~ready_i. Beat order is preserved and no beat is lost or duplicated.
- busy_o = OR of stage valids (combinational).
- out_count_o increments on valid_o & ready_i. It wraps modulo 2^width.
- count_clear_i has priority over a same-cycle increment: the result is 0.

Optional Feature:
Macro ITA_REQUANT_SATCNT_EN.
- Defined: adds output sat_count_o (32 bits). It counts lanes clipped in S3, per accepted output beat (0..N per beat). It saturates at 2^32-1, is cleared by rst_i and count_clear_i, and has the same priority rule as out_count_o.
- Undefined: the port and its logic are absent.

Decomposition:
- Package ita_package holds the shared definitions: oup_t, requant_oup_t, requant_const_array_t, requant_array_t, step_e, counter_t, N_REQUANT_CONSTS, REQUANT_MODE.
- Add a package function step_to_const_idx(step_e) returning the constant index.
- One sub-module, ita_requant_lane. It implements per-lane S1..S3 datapath registers only. The handshake and valid logic stay in the top, and the top instantiates N lanes.

Test Plan:
- Lane data=1000, step=Q with eps=2, shift=4, add=3 -> (2008>>>4)=125, +3=128, output 127 (clipped), 3 cycles after handshake.
- data=-1000, eps=2, shift=4, add=0 -> (-1992>>>4) = -125.
- data=5, eps=3, shift=0, add=-2 -> 13.
- Per-beat constants: alternating beats tagged Q (eps=1) and F2 (eps=4), data=10, shift=0, add=0 -> outputs alternate 10, 40.
- Backpressure: ready_i low for 5 cycles, 4 beats offered back-to-back -> 3 beats held and ready_o low. Then 4 outputs in order, out_count_o=4, data_o stable while stalled.
- Reset and edge cases:
  - rst_i for 1 cycle with 2 beats in flight -> no valid_o afterwards.
  - A step=Idle beat -> illegal_step_o pulses once and no output.
  - count_clear_i with a simultaneous handshake -> out_count_o=0.

Source files
------------

// File: rtl/ita_requant_pipe_pkg.sv
// Shared definitions for the ITA requantizer: lane geometry, step tags,
// bus types and the step-to-constant-set mapping.
package ita_package;

    localparam int unsigned N                = 16;
    localparam int unsigned WO               = 26;
    localparam int unsigned WI               = 8;
    localparam int unsigned EMS              = 8;
    localparam int unsigned N_REQUANT_CONSTS = 8;
    localparam int unsigned CNT_W            = 32;
    localparam int unsigned PROD_W           = WO + EMS + 1;
    localparam int unsigned CIDX_W           = $clog2(N_REQUANT_CONSTS);

    typedef enum logic {
        REQ_SIGNED   = 1'b0,
        REQ_UNSIGNED = 1'b1
    } requant_mode_e;

    // Output lanes are two's complement; clip bounds follow this mode.
    localparam requant_mode_e REQUANT_MODE = REQ_SIGNED;

    typedef enum logic [3:0] {
        Q      = 4'd0,
        K      = 4'd1,
        V      = 4'd2,
        QK     = 4'd3,
        AV     = 4'd4,
        OW     = 4'd5,
        F1     = 4'd6,
        F2     = 4'd7,
        MatMul = 4'd8,
        Idle   = 4'd9
    } step_e;

    typedef logic signed [N-1:0][WO-1:0]               oup_t;
    typedef logic        [N-1:0][WI-1:0]               requant_oup_t;
    typedef logic        [N_REQUANT_CONSTS-1:0][EMS-1:0] requant_const_array_t;
    typedef logic signed [N_REQUANT_CONSTS-1:0][WI-1:0]  requant_array_t;
    typedef logic        [CNT_W-1:0]                   counter_t;

    // Generic matmul shares the first feed-forward constant set; Idle has
    // no set of its own and never reaches the datapath.
    function automatic logic [CIDX_W-1:0] step_to_const_idx(input step_e step);
        logic [CIDX_W-1:0] idx;
        case (step)
            Q:       idx = 3'd0;
            K:       idx = 3'd1;
            V:       idx = 3'd2;
            QK:      idx = 3'd3;
            AV:      idx = 3'd4;
            OW:      idx = 3'd5;
            F1:      idx = 3'd6;
            F2:      idx = 3'd7;
            MatMul:  idx = 3'd6;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ita_requant_lane.sv
// One requant lane: S1 multiply, S2 round/shift, S3 offset/clip registers.
// Flow control lives in the parent; this block only loads on ld*_i.
module ita_requant_lane
    import ita_package::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld1_i,
    input  logic                  ld2_i,
    input  logic                  ld3_i,
    input  logic signed [WO-1:0]  data_i,
    input  logic        [EMS-1:0] eps_mult_i,
    input  logic        [EMS-1:0] right_shift_i,
    input  logic signed [WI-1:0]  add_i,
    output logic signed [WI-1:0]  data_o,
    output logic                  clip_o
);

    // One extra bit over the product covers the rounding term and the offset.
    localparam int unsigned ACC_W  = PROD_W + 1;
    localparam int unsigned MAX_SH = PROD_W - 1;
    localparam logic [EMS-1:0] SH_MAX = EMS'(MAX_SH);
    localparam logic [EMS-1:0] SH_ONE = EMS'(1);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] CLIP_HI =
        (REQUANT_MODE == REQ_SIGNED) ? ACC_W'((2 ** (WI - 1)) - 1) : ACC_W'((2 ** WI) - 1);
    localparam logic signed [ACC_W-1:0] CLIP_LO =
        (REQUANT_MODE == REQ_SIGNED) ? ACC_W'(-(2 ** (WI - 1))) : ACC_W'(0);

    logic signed [PROD_W-1:0] data_ext_s;
    logic signed [PROD_W-1:0] eps_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] prod_r;
    logic        [EMS-1:0]    sh_eff_s;
    logic signed [ACC_W-1:0]  prod_acc_s;
    logic signed [ACC_W-1:0]  rnd_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [PROD_W-1:0] quo_r;
    logic signed [ACC_W-1:0]  res_s;
    logic signed [WI-1:0]     clipped_s;
    logic                     clip_s;
    logic signed [WI-1:0]     data_r;
    logic                     clip_r;

    // S1 operand: signed data times eps treated as unsigned.
    always_comb begin
        data_ext_s = {{(PROD_W-WO){data_i[WO-1]}}, data_i};
        eps_ext_s  = {{(PROD_W-EMS){1'b0}}, eps_mult_i};
        prod_s     = data_ext_s * eps_ext_s;
    end

    // S1 register: product of the accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_r <= '0;
        end else if (ld1_i) begin
            prod_r <= prod_s;
        end
    end

    // S2 operand: round half-up then arithmetic shift; oversized shifts clamp.
    always_comb begin
        if (right_shift_i > SH_MAX) begin
            sh_eff_s = SH_MAX;
        end else begin
            sh_eff_s = right_shift_i;
        end
        prod_acc_s = {prod_r[PROD_W-1], prod_r};
        if (sh_eff_s == '0) begin
            rnd_s = '0;
        end else begin
            rnd_s = ACC_ONE <<< (sh_eff_s - SH_ONE);
        end
        sum_s     = prod_acc_s + rnd_s;
        shifted_s = sum_s >>> sh_eff_s;
    end

    // S2 register: shifted quotient.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_r <= '0;
        end else if (ld2_i) begin
            quo_r <= shifted_s[PROD_W-1:0];
        end
    end

    // S3 operand: add the sign-extended offset and clip to the output range.
    always_comb begin
        res_s = {quo_r[PROD_W-1], quo_r} + {{(ACC_W-WI){add_i[WI-1]}}, add_i};
        if (res_s > CLIP_HI) begin
            clipped_s = CLIP_HI[WI-1:0];
            clip_s    = 1'b1;
        end else if (res_s < CLIP_LO) begin
            clipped_s = CLIP_LO[WI-1:0];
            clip_s    = 1'b1;
        end else begin
            clipped_s = res_s[WI-1:0];
            clip_s    = 1'b0;
        end
    end

    // S3 register: lane output and its clip flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r <= '0;
            clip_r <= 1'b0;
        end else if (ld3_i) begin
            data_r <= clipped_s;
            clip_r <= clip_s;
        end
    end

    assign data_o = data_r;
    assign clip_o = clip_r;

endmodule

// File: rtl/ita_requant_pipe.sv
// Three-stage requantizer between the ITA accumulator and the output FIFO.
// Constant set is chosen per beat from step_i and captured with the beat.
// Optional macro ITA_REQUANT_SATCNT_EN adds sat_count_o (clipped-lane count).
module ita_requant_pipe
    import ita_package::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  oup_t                 data_i,
    input  step_e                step_i,
    input  requant_const_array_t eps_mult_i,
    input  requant_const_array_t right_shift_i,
    input  requant_array_t       add_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output requant_oup_t         data_o,
    input  logic                 count_clear_i,
    output counter_t             out_count_o,
    output logic                 illegal_step_o,
    output logic                 busy_o
`ifdef ITA_REQUANT_SATCNT_EN
    ,
    output logic [31:0]          sat_count_o
`endif
);

    localparam counter_t CNT_ONE = counter_t'(1);

    logic                     v1_r, v2_r, v3_r;
    logic                     en1_s, en2_s, en3_s;
    logic                     accept_s, keep_s, out_fire_s;
    logic                     ld1_s, ld2_s, ld3_s;
    logic [CIDX_W-1:0]        idx_s;
    logic [EMS-1:0]           eps_sel_s, sh_sel_s;
    logic signed [WI-1:0]     add_sel_s;
    logic [EMS-1:0]           sh1_r;
    logic signed [WI-1:0]     add1_r, add2_r;
    requant_oup_t             lane_out_s;
    logic [N-1:0]             clip_s;
    logic                     illegal_r;
    counter_t                 cnt_r;

    // Stage enables: a stage may load when it is empty or its content moves on.
    always_comb begin
        en3_s      = ~v3_r | ready_i;
        en2_s      = ~v2_r | en3_s;
        en1_s      = ~v1_r | en2_s;
        accept_s   = valid_i & en1_s;
        keep_s     = accept_s & (step_i != Idle);
        ld1_s      = keep_s;
        ld2_s      = en2_s & v1_r;
        ld3_s      = en3_s & v2_r;
        out_fire_s = v3_r & ready_i;
    end

    // Constant set selected by the incoming beat's step tag.
    always_comb begin
        idx_s     = step_to_const_idx(step_i);
        eps_sel_s = eps_mult_i[idx_s];
        sh_sel_s  = right_shift_i[idx_s];
        add_sel_s = add_i[idx_s];
    end

    // Stage valid bits; Idle beats are accepted but leave S1 empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (en1_s) v1_r <= keep_s;
            if (en2_s) v2_r <= v1_r;
            if (en3_s) v3_r <= v2_r;
        end
    end

    // Shift and offset travel alongside the beat so constants stay per beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh1_r  <= '0;
            add1_r <= '0;
            add2_r <= '0;
        end else begin
            if (ld1_s) begin
                sh1_r  <= sh_sel_s;
                add1_r <= add_sel_s;
            end
            if (ld2_s) begin
                add2_r <= add1_r;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        ita_requant_lane u_lane (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .ld1_i         (ld1_s),
            .ld2_i         (ld2_s),
            .ld3_i         (ld3_s),
            .data_i        (data_i[k]),
            .eps_mult_i    (eps_sel_s),
            .right_shift_i (sh1_r),
            .add_i         (add2_r),
            .data_o        (lane_out_s[k]),
            .clip_o        (clip_s[k])
        );
    end

    // One-cycle flag for an accepted Idle beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept_s & (step_i == Idle);
        end
    end

    // Output handshake counter; clear wins over a same-cycle handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i || count_clear_i) begin
            cnt_r <= '0;
        end else if (out_fire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

`ifdef ITA_REQUANT_SATCNT_EN
    localparam int unsigned CLIPCNT_W = $clog2(N + 1);

    logic [31:0] sat_r;
    logic [32:0] sat_sum_s;

    function automatic logic [CLIPCNT_W-1:0] clip_count(input logic [N-1:0] flags);
        logic [CLIPCNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{(CLIPCNT_W-1){1'b0}}, flags[i]};
        end
        return c;
    endfunction

    // Candidate saturating sum for the beat leaving S3.
    always_comb begin
        sat_sum_s = {1'b0, sat_r} + {{(33-CLIPCNT_W){1'b0}}, clip_count(clip_s)};
    end

    // Clipped-lane counter, saturating at all ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || count_clear_i) begin
            sat_r <= '0;
        end else if (out_fire_s) begin
            if (sat_sum_s[32]) begin
                sat_r <= 32'hFFFF_FFFF;
            end else begin
                sat_r <= sat_sum_s[31:0];
            end
        end
    end

    assign sat_count_o = sat_r;
`else
    logic unused_clip_s;
    assign unused_clip_s = ^clip_s;
`endif

    assign ready_o        = en1_s;
    assign valid_o        = v3_r;
    assign data_o         = lane_out_s;
    assign out_count_o    = cnt_r;
    assign illegal_step_o = illegal_r;
    assign busy_o         = v1_r | v2_r | v3_r;

endmodule
